comet2_serial_sub: RTL
======================

Name: comet2_serial_sub

Overview:
Bit-serial 16-bit subtractor/comparator for the COMET2 ALU. It is the inverse operation to the combinational adder path and computes D = A − B LSB-first, one bit per clock, as A + ~B + 1. It produces the COMET2 flag-register bits OF/SF/ZF for SUBA/CPA (arithmetic) or SUBL/CPL (logical). A start/done handshake lets the sequencer issue an operation and wait for the result.

Parameters:
WIDTH, 16, operand/result width in bits (COMET2 word).

Ports:
clk      input   1      rising-edge clock
rst      input   1      synchronous, active-high reset
start    input   1      request; sampled only in IDLE
a        input   WIDTH  minuend; captured on accepted start
b        input   WIDTH  subtrahend; captured on accepted start
logical  input   1      0 = arithmetic flags (SUBA/CPA), 1 = logical flags (SUBL/CPL); captured on start
busy     output  1      high while an operation is in progress (RUN or DONE)
done     output  1      one-cycle pulse; d and flags valid from this cycle
d        output  WIDTH  difference A − B, modulo 2^WIDTH
of       output  1      overflow flag
sf       output  1      sign flag
zf       output  1      zero flag

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset (rst high at a clk edge): state = IDLE. busy, done, d, of, sf, zf all 0. Any operation in flight is abandoned and no done pulse follows.
- States:
  - IDLE: on start=1, capture a, b and logical into shift registers, set carry = 1, set bit counter = 0, go to RUN.
  - RUN: each clock, full-add a_sr[0] + ~b_sr[0] + carry. Shift the sum bit into the result MSB side, shift both operand registers right, update carry, and increment the counter. After the WIDTH-th bit (counter == WIDTH−1), go to DONE.
  - DONE: done = 1 for exactly this cycle. d and flags are updated on entry to DONE. Next state is IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH (WIDTH+1 edges from acceptance). Issue rate is at most one operation per WIDTH+2 cycles.
- busy = 1 in RUN and DONE, 0 in IDLE. busy is registered and rises the cycle after start is accepted.
- start while busy is ignored and not queued. a, b and logical may change freely after acceptance.
- d and flags hold their last values until the next DONE or a reset. Partial results are never visible on d.
- Flag rules (Cout = final carry out):
  - Arithmetic: of = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]); sf = d[MSB]; zf = (d == 0).
  - Logical: of = ~Cout (borrow, i.e. a < b unsigned); sf = d[MSB]; zf = (d == 0).
- Boundary conditions:
  - a == b gives d = 0, zf = 1, of = 0 in both modes.
  - b = 0 gives d = a; of = 0 in both modes.
  - Wrap-around is modulo 2^WIDTH with no saturation.
  - start asserted in the DONE cycle is ignored; it is accepted only if still high in the following IDLE cycle.
  - rst and start high together: rst wins.

Decomposition:
- Package comet2_alu_pkg:
  - WORD_W = 16
  - state encoding IDLE/RUN/DONE (2 bits)
  - flag-index constants FLAG_OF = 2, FLAG_SF = 1, FLAG_ZF = 0, shared with the FR register
- Sub-module comet2_fa1: 1-bit full adder cell (x, y, cin -> s, cout), instantiated once with y = ~b_sr[0].
- Control FSM, counter and shift registers stay in the top module.

Test Plan:
- Reset, then a = 0x0005, b = 0x0003, logical = 0, one-cycle start -> busy rises next cycle; done after 17 edges; d = 0x0002, of = 0, sf = 0, zf = 0.
- a = 0x8000, b = 0x0001, logical = 0 -> d = 0x7FFF, of = 1, sf = 0, zf = 0. Same operands with logical = 1 -> d = 0x7FFF, of = 0, sf = 0.
- a = 0x0001, b = 0x0002, logical = 1 -> d = 0xFFFF, of = 1 (borrow), sf = 1, zf = 0. Same operands with logical = 0 -> of = 0, sf = 1.
- a = b = 0x1234 in both modes -> d = 0x0000, zf = 1, of = 0, sf = 0.
- Start with a = 0x0009, b = 0x0004, then pulse start with a = 0x00FF, b = 0x0000 at RUN cycle 5 -> single done; d = 0x0005; no second operation begins.
- Start with a = 0x0010, b = 0x0001, assert rst at RUN cycle 8 -> all outputs 0 next cycle, no done pulse. A subsequent fresh start with a = 0x0003, b = 0x0003 completes normally with zf = 1.

Source files
------------

// File: rtl/comet2_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comet2_alu_pkg
//  Description : Shared constants for the COMET2 ALU slice: word width,
//                serial-subtractor state encoding and flag-register indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package comet2_alu_pkg;

    // COMET2 machine word width
    localparam int WORD_W = 16;

    // Serial subtractor control states
    typedef logic [1:0] state_t;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Bit positions inside the FR flag register
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_ZF = 0;

endpackage : comet2_alu_pkg
`default_nettype wire

// File: rtl/comet2_fa1.sv
`default_nettype none
// ============================================================================
//  Module      : comet2_fa1
//  Description : Single-bit full adder cell used by the serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module comet2_fa1 (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three one-bit inputs
    always_comb begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule : comet2_fa1
`default_nettype wire

// File: rtl/comet2_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : comet2_serial_sub
//  Description : Bit-serial subtractor/comparator. Computes d = a - b as
//                a + ~b + 1, LSB first, one bit per clock, and produces the
//                COMET2 OF/SF/ZF flags for arithmetic or logical compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module comet2_serial_sub
    import comet2_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             logical,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Holds the first WIDTH-1 sum bits; the last bit joins them directly
    // when the result is published, so d never shows a partial value.
    logic [WIDTH-2:0] r_res_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_logical;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic [2:0]       r_flags;

    logic             w_nb;
    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_d_final;
    logic [2:0]       w_flags;

    assign w_nb = ~r_b_sr[0];

    comet2_fa1 u_fa (
        .x    (r_a_sr[0]),
        .y    (w_nb),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Final result and flags, meaningful on the last RUN bit where the
    // operand LSBs are the original sign bits and w_sum is the result MSB.
    always_comb begin
        w_d_final        = {w_sum, r_res_sr};
        w_flags          = '0;
        w_flags[FLAG_SF] = w_sum;
        w_flags[FLAG_ZF] = (w_d_final == '0);
        if (r_logical) begin
            w_flags[FLAG_OF] = ~w_cout;
        end else begin
            w_flags[FLAG_OF] = (r_a_sr[0] != r_b_sr[0]) && (w_sum != r_a_sr[0]);
        end
    end

    // Control FSM, bit counter, operand/result shift registers and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_res_sr  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_logical <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_d       <= '0;
            r_flags   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= b;
                        r_logical <= logical;
                        r_carry   <= 1'b1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_res_sr <= {w_sum, r_res_sr[WIDTH-2:1]};
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST_BIT) begin
                        r_d     <= w_d_final;
                        r_flags <= w_flags;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign of   = r_flags[FLAG_OF];
    assign sf   = r_flags[FLAG_SF];
    assign zf   = r_flags[FLAG_ZF];

endmodule : comet2_serial_sub
`default_nettype wire
